shape_sfr_initiator: RTL and testbench
======================================

# shape_sfr_initiator

Bus initiator for the shape processor's CTRL SFR. It accepts write-and-verify or read-only-verify commands over a valid/ready interface and drives the processor's single-cycle `write`/`read` strobes. It reads CTRL back and compares it against a shadow copy of the value CTRL must hold, then returns a status per command. It sits between a test/config controller and the shape processor's register port, and provides the transmit side of that port.

## Interface
Parameters:
- `CTRL_RESET_VALUE`, default 32'h0000_0000: CTRL value after shape processor reset. Loads the shadow register.
- `CNT_W`, default 16: width of the saturating statistics counters.

Ports:
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  initiator can accept a command.
- `cmd_read_only`  in  1  1 = read-and-verify only; 0 = write then read-and-verify.
- `cmd_shape`  in  2  SHAPE field to write.
- `cmd_operation`  in  5  OPERATION field to write.
- `write`  out  1  single-cycle write strobe to the processor.
- `write_data`  out  32  CTRL write data.
- `read`  out  1  single-cycle read strobe.
- `read_data`  in  32  CTRL read data; valid the cycle after `read`.
- `error`  in  1  processor error flag; sampled the cycle after `write`.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_status`  out  2  0 OK, 1 REJECTED_OK (illegal shape, CTRL unchanged), 2 MISMATCH.
- `rsp_error`  out  1  captured `error` (0 for read-only commands).
- `rsp_ctrl`  out  32  CTRL value read back.
- `ok_count`, `mismatch_count`  out  CNT_W  saturating statistics.

## Operation
- CTRL layout: [31:18] reserved, [17:16] SHAPE, [15:5] reserved, [4:0] OPERATION. `write_data = {14'b0, cmd_shape, 11'b0, cmd_operation}`.
- Legal SHAPE: 2'b01 RECTANGLE, 2'b10 TRIANGLE. 2'b00 and 2'b11 are illegal.
- Shadow update on a write command: legal shape updates shadow SHAPE and OPERATION. Illegal shape leaves the shadow unchanged, because the processor must drop the whole write.
- Compare covers only bits [17:16] and [4:0]. Reserved bits are ignored.
- Status selection:
  - mismatch → MISMATCH;
  - match with an illegal-shape write → REJECTED_OK;
  - otherwise → OK.
- Counters: `ok_count` increments on OK or REJECTED_OK; `mismatch_count` increments on MISMATCH. Both saturate at all-ones.
- FSM states:
  - IDLE: `cmd_ready`=1. On handshake, latch the command. Go to WRITE, or to READ if `cmd_read_only`.
  - WRITE: `write`=1 with `write_data`. Go to READ.
  - READ: `read`=1. Capture `error` if the previous state was WRITE. Go to CHECK.
  - CHECK: sample `read_data`, compare, update shadow/counters, load the rsp_* registers. Go to RESP.
  - RESP: `rsp_valid`=1 with stable fields until `rsp_ready`. Then go to IDLE.
- `write` and `read` are never high in the same cycle and never high outside WRITE/READ. `write_data` is 0 when `write`=0.

## Timing
- Reset values: all outputs 0 (including `cmd_ready`) in the cycle `rst` is high; shadow = `CTRL_RESET_VALUE`; counters 0; state IDLE.
- `cmd_ready` rises the first cycle after `rst` deasserts.
- Write command handshake at cycle T:
  - `write` at T+1;
  - `read` at T+2;
  - `read_data` sampled at T+3;
  - `rsp_valid` at T+4.
- Read-only command handshake at cycle T: `read` at T+1, `rsp_valid` at T+3.
- `rsp_valid`&&`rsp_ready` at cycle R: `cmd_ready`=1 at R+1. There is no command/response overlap, so at most one command is in flight.
- `rsp_ready` held high: one command per 5 cycles (write) or 4 cycles (read-only).
- Shadow and counters update at the end of CHECK, so they are visible with `rsp_valid`.
- `rst` in any state, including with `rsp_valid` pending: the in-flight command is dropped with no response and no counter update. Shadow and counters return to reset values.
- `cmd_valid` while `cmd_ready`=0 is ignored. The command fields must be held by the source until accepted.

## Test plan
- Reset, then read-only command with `read_data`=`CTRL_RESET_VALUE` → `read` at T+1, `rsp_valid` at T+3, status OK, `ok_count`=1.
- Write shape 2'b01, operation 5'h0A; processor returns 32'h0001_000A → `write_data`=32'h0001_000A at T+1, status OK. A following read-only command expects the same value.
- Write shape 2'b11, operation 5'h1F after the prior command; processor returns 32'h0001_000A, `error`=1 → status REJECTED_OK, `rsp_error`=1, shadow unchanged.
- Write shape 2'b10, operation 5'h03; processor returns 32'h0001_0003 → MISMATCH, `mismatch_count`=1. Returning 32'hFFFE_FFE3 instead (reserved bits set) → OK.
- `rsp_ready` held low 10 cycles → `rsp_valid` and fields stable, `cmd_ready`=0 throughout. `rst` pulsed in cycle 5 → all outputs 0 next cycle, counters 0.
- 2^CNT_W+2 OK commands (CNT_W overridden to 4): `ok_count` saturates at 4'hF.

Source files
------------

// File: rtl/shape_sfr_initiator.sv
// shape_sfr_initiator: issues write-then-verify or read-only-verify accesses to
// the shape processor's CTRL register and reports a status per command.
// CTRL is checked against a shadow of the value it should hold. Only the
// SHAPE [17:16] and OPERATION [4:0] fields are compared.
module shape_sfr_initiator #(
    parameter logic [31:0] CTRL_RESET_VALUE = 32'h0000_0000,
    parameter int          CNT_W            = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_read_only,
    input  logic [1:0]       cmd_shape,
    input  logic [4:0]       cmd_operation,
    output logic             write,
    output logic [31:0]      write_data,
    output logic             read,
    input  logic [31:0]      read_data,
    input  logic             error,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_status,
    output logic             rsp_error,
    output logic [31:0]      rsp_ctrl,
    output logic [CNT_W-1:0] ok_count,
    output logic [CNT_W-1:0] mismatch_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_REJECTED = 2'd1;
    localparam logic [1:0] ST_MISMATCH = 2'd2;

    // Bits of CTRL that carry state: SHAPE and OPERATION. The rest are reserved.
    localparam logic [31:0] CMP_MASK = 32'h0003_001F;

    logic [2:0]       r_state;
    logic             r_read_only;
    logic [1:0]       r_shape;
    logic [4:0]       r_op;
    logic             r_err;
    logic [31:0]      r_shadow;
    logic [1:0]       r_rsp_status;
    logic             r_rsp_error;
    logic [31:0]      r_rsp_ctrl;
    logic [CNT_W-1:0] r_ok_cnt;
    logic [CNT_W-1:0] r_mis_cnt;

    logic             w_shape_legal;
    logic             w_shadow_upd;
    logic [31:0]      w_write_data;
    logic [31:0]      w_shadow_next;
    logic [31:0]      w_bit_diff;
    logic             w_mismatch;
    logic [1:0]       w_status;
    logic             w_out_en;

    // Only RECTANGLE (01) and TRIANGLE (10) are accepted by the processor.
    assign w_shape_legal = (r_shape == 2'b01) || (r_shape == 2'b10);
    assign w_write_data  = {14'b0, r_shape, 11'b0, r_op};

    // The processor drops an illegal-shape write entirely, so the shadow
    // follows only legal writes. Compare against the post-write expectation.
    assign w_shadow_upd  = !r_read_only && w_shape_legal;
    assign w_shadow_next = w_shadow_upd ? {r_shadow[31:18], r_shape, r_shadow[15:5], r_op}
                                        : r_shadow;

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_cmp
            assign w_bit_diff[gi] = CMP_MASK[gi] & (read_data[gi] ^ w_shadow_next[gi]);
        end
    endgenerate

    assign w_mismatch = |w_bit_diff;
    assign w_status   = w_mismatch                          ? ST_MISMATCH :
                        (!r_read_only && !w_shape_legal)    ? ST_REJECTED : ST_OK;

    // Command sequencing: IDLE -> [WRITE] -> READ -> CHECK -> RESP -> IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_read_only <= 1'b0;
            r_shape     <= 2'b00;
            r_op        <= 5'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_read_only <= cmd_read_only;
                        r_shape     <= cmd_shape;
                        r_op        <= cmd_operation;
                        r_state     <= cmd_read_only ? S_READ : S_WRITE;
                    end
                end
                S_WRITE: r_state <= S_READ;
                S_READ:  r_state <= S_CHECK;
                S_CHECK: r_state <= S_RESP;
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Error flag is valid the cycle after the write strobe, i.e. during READ
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (r_state == S_READ) begin
            r_err <= r_read_only ? 1'b0 : error;
        end
    end

    // Check result: shadow commit and response registers loaded at end of CHECK
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow     <= CTRL_RESET_VALUE;
            r_rsp_status <= 2'b00;
            r_rsp_error  <= 1'b0;
            r_rsp_ctrl   <= 32'b0;
        end else if (r_state == S_CHECK) begin
            r_shadow     <= w_shadow_next;
            r_rsp_status <= w_status;
            r_rsp_error  <= r_err;
            r_rsp_ctrl   <= read_data;
        end
    end

    // Saturating statistics, updated together with the response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ok_cnt  <= '0;
            r_mis_cnt <= '0;
        end else if (r_state == S_CHECK) begin
            if (w_status == ST_MISMATCH) begin
                if (r_mis_cnt != '1) begin
                    r_mis_cnt <= r_mis_cnt + CNT_W'(1);
                end
            end else if (r_ok_cnt != '1) begin
                r_ok_cnt <= r_ok_cnt + CNT_W'(1);
            end
        end
    end

    // Every output is forced low while reset is asserted, whatever the state.
    assign w_out_en       = ~rst;
    assign cmd_ready      = w_out_en && (r_state == S_IDLE);
    assign write          = w_out_en && (r_state == S_WRITE);
    assign write_data     = write ? w_write_data : 32'b0;
    assign read           = w_out_en && (r_state == S_READ);
    assign rsp_valid      = w_out_en && (r_state == S_RESP);
    assign rsp_status     = w_out_en ? r_rsp_status : 2'b00;
    assign rsp_error      = w_out_en && r_rsp_error;
    assign rsp_ctrl       = w_out_en ? r_rsp_ctrl : 32'b0;
    assign ok_count       = w_out_en ? r_ok_cnt : '0;
    assign mismatch_count = w_out_en ? r_mis_cnt : '0;

endmodule

// File: tb/tb_shape_sfr_initiator.sv
// Testbench for shape_sfr_initiator: directed vector table, reset/backpressure
// sequences, counter saturation and randomized commands against a field-level model.
module tb_shape_sfr_initiator;

    localparam logic [31:0] RST_VAL = 32'h0002_0005;
    localparam int          CW      = 4;
    localparam int          SAT     = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_read_only;
    logic [1:0]    cmd_shape;
    logic [4:0]    cmd_operation;
    logic          write;
    logic [31:0]   write_data;
    logic          read;
    logic [31:0]   read_data;
    logic          error;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_status;
    logic          rsp_error;
    logic [31:0]   rsp_ctrl;
    logic [CW-1:0] ok_count;
    logic [CW-1:0] mismatch_count;

    int checks = 0;
    int errors = 0;

    // Reference model: the CTRL fields the processor should hold, and counters
    logic [1:0] m_shape;
    logic [4:0] m_op;
    int         m_ok;
    int         m_mis;

    typedef struct {
        bit          ro;
        logic [1:0]  sh;
        logic [4:0]  op;
        logic [31:0] rd;
        bit          er;
        int          hold;
        logic [1:0]  st;
        bit          re;
        int          okc;
        int          mis;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    shape_sfr_initiator #(
        .CTRL_RESET_VALUE (RST_VAL),
        .CNT_W            (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_read_only  (cmd_read_only),
        .cmd_shape      (cmd_shape),
        .cmd_operation  (cmd_operation),
        .write          (write),
        .write_data     (write_data),
        .read           (read),
        .read_data      (read_data),
        .error          (error),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_status     (rsp_status),
        .rsp_error      (rsp_error),
        .rsp_ctrl       (rsp_ctrl),
        .ok_count       (ok_count),
        .mismatch_count (mismatch_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
        chk({tag, "_write"}, 32'(write), 32'd0);
        chk({tag, "_write_data"}, write_data, 32'd0);
        chk({tag, "_read"}, 32'(read), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_status"}, 32'(rsp_status), 32'd0);
        chk({tag, "_rsp_error"}, 32'(rsp_error), 32'd0);
        chk({tag, "_rsp_ctrl"}, rsp_ctrl, 32'd0);
        chk({tag, "_ok_count"}, 32'(ok_count), 32'd0);
        chk({tag, "_mismatch_count"}, 32'(mismatch_count), 32'd0);
    endtask

    task automatic model_reset();
        m_shape = RST_VAL[17:16];
        m_op    = RST_VAL[4:0];
        m_ok    = 0;
        m_mis   = 0;
    endtask

    // Apply one command to the model and return the status it must produce
    task automatic model_apply(input bit ro, input logic [1:0] sh, input logic [4:0] op,
                               input logic [31:0] rd, output logic [1:0] st);
        bit legal;
        legal = (sh == 2'b01) || (sh == 2'b10);
        if (!ro && legal) begin
            m_shape = sh;
            m_op    = op;
        end
        if (rd[17:16] != m_shape || rd[4:0] != m_op) begin
            st = 2'd2;
            if (m_mis < SAT) m_mis++;
        end else begin
            st = (!ro && !legal) ? 2'd1 : 2'd0;
            if (m_ok < SAT) m_ok++;
        end
    endtask

    // Drive one command, play the processor side, check strobe timing and
    // response stability. Optionally pulse rst during the response hold.
    task automatic run_cmd(input bit ro, input logic [1:0] sh, input logic [4:0] op,
                           input logic [31:0] rd, input bit er, input int hold, input int rst_at,
                           output logic [1:0] st, output logic re, output logic [31:0] rc,
                           output int okc, output int mc, output bit aborted);
        int          n;
        int          wr_at;
        int          rd_at;
        int          rv_at;
        int          n_wr;
        int          n_rd;
        bit          prev_wr;
        bit          prev_rd;
        bit          cur_wr;
        bit          cur_rd;
        logic [31:0] exp_wd;

        aborted = 1'b0;
        st = 2'd0; re = 1'b0; rc = 32'd0; okc = 0; mc = 0;
        exp_wd        = {14'b0, sh, 11'b0, op};
        read_data     = ~rd;
        error         = ~er;
        cmd_valid     = 1'b1;
        cmd_read_only = ro;
        cmd_shape     = sh;
        cmd_operation = op;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            fail_timeout("cmd_ready_wait");
            cmd_valid = 1'b0;
            aborted   = 1'b1;
            return;
        end

        wr_at = -1; rd_at = -1; rv_at = -1; n_wr = 0; n_rd = 0;
        prev_wr = 1'b0; prev_rd = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) begin
                cmd_valid     = 1'b0;
                cmd_read_only = 1'($urandom_range(0, 1));
                cmd_shape     = 2'($urandom_range(0, 3));
                cmd_operation = 5'($urandom_range(0, 31));
            end
            cur_wr = write;
            cur_rd = read;
            if (cur_wr) begin
                n_wr++;
                if (wr_at < 0) wr_at = c;
            end
            if (cur_rd) begin
                n_rd++;
                if (rd_at < 0) rd_at = c;
            end
            chk("write_data", write_data, cur_wr ? exp_wd : 32'd0);
            chk("wr_rd_exclusive", 32'(cur_wr & cur_rd), 32'd0);
            if (rsp_valid) begin
                rv_at = c;
                break;
            end
            chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
            // Processor side: data only valid in the cycle after each strobe
            read_data = prev_rd ? rd : ~rd;
            error     = prev_wr ? er : ~er;
            prev_wr   = cur_wr;
            prev_rd   = cur_rd;
        end
        if (rv_at < 0) begin
            fail_timeout("rsp_valid_wait");
            aborted = 1'b1;
            return;
        end
        chk("rsp_latency", 32'(rv_at), ro ? 32'd3 : 32'd4);
        chk("read_cycle", 32'(rd_at), ro ? 32'd1 : 32'd2);
        chk("read_count", 32'(n_rd), 32'd1);
        chk("write_count", 32'(n_wr), ro ? 32'd0 : 32'd1);
        if (!ro) chk("write_cycle", 32'(wr_at), 32'd1);

        st  = rsp_status;
        re  = rsp_error;
        rc  = rsp_ctrl;
        okc = int'(ok_count);
        mc  = int'(mismatch_count);

        for (int h = 0; h < hold; h++) begin
            if (h == rst_at) begin
                rst = 1'b1;
                #1;
                chk_all_zero("rst_pulse");
                @(negedge clk);
                rst = 1'b0;
                #1;
                chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
                chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
                chk("post_rst_ok_count", 32'(ok_count), 32'd0);
                chk("post_rst_mismatch_count", 32'(mismatch_count), 32'd0);
                aborted = 1'b1;
                $display("txn ro=%0d shape=%b op=%h aborted by reset during response hold", ro, sh, op);
                return;
            end
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("hold_rsp_status", 32'(rsp_status), 32'(st));
            chk("hold_rsp_error", 32'(rsp_error), 32'(re));
            chk("hold_rsp_ctrl", rsp_ctrl, rc);
            chk("hold_ok_count", 32'(ok_count), 32'(okc));
        end

        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        chk("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
        $display("txn ro=%0d shape=%b op=%h rdata=%h err=%0d -> status=%0d rsp_error=%0d rsp_ctrl=%h ok=%0d mis=%0d",
                 ro, sh, op, rd, er, st, re, rc, okc, mc);
    endtask

    // Run a command and compare its response with the model
    task automatic do_txn(input bit ro, input logic [1:0] sh, input logic [4:0] op,
                          input logic [31:0] rd, input bit er, input int hold);
        logic [1:0]  st;
        logic [1:0]  exp_st;
        logic        re;
        logic [31:0] rc;
        int          okc;
        int          mc;
        bit          ab;
        run_cmd(ro, sh, op, rd, er, hold, -1, st, re, rc, okc, mc, ab);
        if (!ab) begin
            model_apply(ro, sh, op, rd, exp_st);
            chk("model_status", 32'(st), 32'(exp_st));
            chk("model_rsp_error", 32'(re), ro ? 32'd0 : 32'(er));
            chk("model_rsp_ctrl", rc, rd);
            chk("model_ok_count", 32'(okc), 32'(m_ok));
            chk("model_mismatch_count", 32'(mc), 32'(m_mis));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  st;
        logic [1:0]  exp_st;
        logic        re;
        logic [31:0] rc;
        int          okc;
        int          mc;
        bit          ab;
        bit          ro;
        bit          er;
        bit          legal;
        logic [1:0]  sh;
        logic [4:0]  op;
        logic [31:0] rd;

        //           ro sh     op     rdata          er hold st    re okc mis
        vecs[0]  = '{1, 2'b00, 5'h00, 32'h0002_0005, 0, 0,  2'd0, 0, 1, 0};
        vecs[1]  = '{0, 2'b01, 5'h0A, 32'h0001_000A, 0, 0,  2'd0, 0, 2, 0};
        vecs[2]  = '{1, 2'b00, 5'h00, 32'h0001_000A, 0, 0,  2'd0, 0, 3, 0};
        vecs[3]  = '{0, 2'b11, 5'h1F, 32'h0001_000A, 1, 0,  2'd1, 1, 4, 0};
        vecs[4]  = '{1, 2'b00, 5'h00, 32'h0001_000A, 1, 10, 2'd0, 0, 5, 0};
        vecs[5]  = '{0, 2'b10, 5'h03, 32'h0001_0003, 0, 0,  2'd2, 0, 5, 1};
        vecs[6]  = '{1, 2'b00, 5'h00, 32'hFFFE_FFE3, 0, 0,  2'd0, 0, 6, 1};
        vecs[7]  = '{0, 2'b00, 5'h07, 32'hFFFE_FFE3, 1, 0,  2'd1, 1, 7, 1};
        vecs[8]  = '{1, 2'b00, 5'h00, 32'h0002_0004, 0, 0,  2'd2, 0, 7, 2};
        vecs[9]  = '{0, 2'b01, 5'h1F, 32'h0001_001F, 1, 2,  2'd0, 1, 8, 2};
        vecs[10] = '{0, 2'b10, 5'h15, 32'h0001_0015, 0, 0,  2'd2, 0, 8, 3};
        vecs[11] = '{1, 2'b00, 5'h00, 32'h0002_0015, 0, 0,  2'd0, 0, 9, 3};

        rst = 1'b1; cmd_valid = 1'b0; cmd_read_only = 1'b0; cmd_shape = 2'b00;
        cmd_operation = 5'h00; read_data = 32'h0; error = 1'b0; rsp_ready = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("reset_cmd_ready_rise", 32'(cmd_ready), 32'd1);
        chk("reset_ok_count", 32'(ok_count), 32'd0);

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            run_cmd(vecs[i].ro, vecs[i].sh, vecs[i].op, vecs[i].rd, vecs[i].er,
                    vecs[i].hold, -1, st, re, rc, okc, mc, ab);
            if (!ab) begin
                model_apply(vecs[i].ro, vecs[i].sh, vecs[i].op, vecs[i].rd, exp_st);
                chk($sformatf("vec%0d_status", i), 32'(st), 32'(vecs[i].st));
                chk($sformatf("vec%0d_rsp_error", i), 32'(re), 32'(vecs[i].re));
                chk($sformatf("vec%0d_rsp_ctrl", i), rc, vecs[i].rd);
                chk($sformatf("vec%0d_ok_count", i), 32'(okc), 32'(vecs[i].okc));
                chk($sformatf("vec%0d_mismatch_count", i), 32'(mc), 32'(vecs[i].mis));
            end
        end

        // Reset while a response is pending: dropped, counters and shadow cleared
        run_cmd(1'b0, 2'b01, 5'h11, 32'h0001_0011, 1'b0, 10, 5, st, re, rc, okc, mc, ab);
        chk("rst_abort_flag", 32'(ab), 32'd1);
        model_reset();
        do_txn(1'b1, 2'b00, 5'h00, RST_VAL, 1'b0, 0);
        chk("post_rst_shadow_ok_count", 32'(ok_count), 32'd1);

        // Counter saturation: 2^CW+2 OK commands in total from reset
        for (int i = 0; i < (1 << CW) + 1; i++) begin
            do_txn(1'b1, 2'b00, 5'h00, RST_VAL ^ 32'hFFFC_FFE0, 1'b0, 0);
        end
        chk("ok_count_saturated", 32'(ok_count), 32'(SAT));

        // Randomized commands against the model
        for (int i = 0; i < 60; i++) begin
            ro = 1'($urandom_range(0, 1));
            sh = 2'($urandom_range(0, 3));
            op = 5'($urandom_range(0, 31));
            er = 1'($urandom_range(0, 1));
            rd = $urandom;
            legal = (sh == 2'b01) || (sh == 2'b10);
            if ($urandom_range(0, 2) != 0) begin
                rd[17:16] = (!ro && legal) ? sh : m_shape;
                rd[4:0]   = (!ro && legal) ? op : m_op;
            end
            do_txn(ro, sh, op, rd, er, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
